alu_issue_stage: RTL and testbench
==================================

# alu_issue_stage

Decode-and-issue stage that feeds the pipeline ALU. It turns a fetched 32-bit MIPS-style instruction and its register-file operands into the ALU's `func`/`opcode`/`a`/`b` inputs plus writeback destination, and holds the result in the ID/EX pipeline register. A two-entry skid buffer and valid/ready handshakes on both sides let decode and execute stall independently. Pipeline flush support is built in.

## Interface
- `SIZE`, 32, datapath width (operands, immediates extended to this)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `flush`  in  1  synchronous kill of all buffered and incoming instructions
- `in_valid`  in  1  instruction/operands valid
- `in_ready`  out  1  stage can accept this cycle (registered)
- `instr`  in  32  instruction word
- `rs_val`  in  SIZE  register value for rs
- `rt_val`  in  SIZE  register value for rt
- `out_valid`  out  1  issued entry valid
- `out_ready`  in  1  execute consumes entry
- `func`  out  3  ALU function: 0 add, 1 sub, 2 and, 3 or, 4 not, 5 mov, 6 slt, 7 lui
- `opcode`  out  6  `instr[31:26]` passthrough (ALU uses 000100/000101 for zero_flag)
- `a`, `b`  out  SIZE  ALU operands
- `dst`  out  5  writeback register
- `we`  out  1  writeback enable
- `illegal`  out  1  present only with `ALU_ISSUE_ILLEGAL_EN`

## Operation
- R-type (opcode 000000), `funct`:
  - 0x20/0x21 → add; 0x22/0x23 → sub; 0x24 → and; 0x25 → or; 0x2A → slt; 0x30 → not; 0x31 → mov.
  - `a=rs_val`, `b=rt_val`, `dst=rd`, `we=1`.
- I-type, with `a=rs_val`, `dst=rt`:
  - addi 001000 → add, sign-extended imm, `we=1`.
  - slti 001010 → slt, sign-extended imm, `we=1`.
  - andi 001100 → and, zero-extended imm, `we=1`.
  - ori 001101 → or, zero-extended imm, `we=1`.
  - lui 001111 → func 7, `b`=zero-extended imm (ALU shifts), `we=1`.
  - lw 100011 → add, sign-extended imm, `we=1`.
  - sw 101011 → add, sign-extended imm, `we=0`.
  - beq 000100 / bne 000101 → sub, `b=rt_val`, `we=0`, `dst=0`.
- Any other opcode or funct decodes as func 0, `a=b=0`, `we=0`, `dst=0` (bubble). It is still issued.
- Writes with `dst==0` force `we=0`.
- Skid buffer: main register drives the outputs; the skid register catches one entry when `out_ready` drops.
  - States: EMPTY, ONE (main valid), TWO (main+skid valid).
  - EMPTY→ONE on accept.
  - ONE→TWO on accept with no consume.
  - ONE→EMPTY on consume with no accept.
  - TWO→ONE on consume; skid moves to main.
- `in_ready` = state != TWO, registered.
- Issue order is strictly preserved. Accept and consume in the same cycle in ONE keeps ONE, and the new entry replaces main.

## Timing
- Latency 1 cycle: an entry accepted at edge N is visible on the outputs after edge N when the buffer was EMPTY.
- Throughput 1 instruction/cycle while `out_ready=1`.
- Outputs hold stable while `out_valid && !out_ready`.
- Reset values: state EMPTY, `out_valid=0`, `in_ready=1`, `func=0`, `opcode=0`, `a=b=0`, `dst=0`, `we=0`, `illegal=0`.
- `flush` at edge N:
  - State goes to EMPTY and `out_valid=0` after N.
  - Any `in_valid` in that cycle is dropped.
  - `in_ready=1` after N.
  - `flush` overrides accept and consume.
- Reset mid-stall discards all entries immediately; it does not wait for a clock edge.

## Configuration
- `ALU_ISSUE_ILLEGAL_EN` defined: the `illegal` port exists and is registered with its entry. It is 1 for undecoded opcode/funct; the entry still issues as a bubble.
- Not defined: the port is absent and undecoded instructions silently become bubbles.

## Structure
- Package `alu_pkg`:
  - func code constants (ALU_ADD … ALU_LUI)
  - opcode constants (OP_RTYPE, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE)
  - funct constants
  - issue-entry struct typedef
- Sub-module `alu_func_decode`: purely combinational instruction → entry decode, instantiated once. The skid buffer and FSM live in the top.

## Test plan
- add: `instr=0x00221820`, `rs_val=5`, `rt_val=7`, `out_ready=1` → next cycle `func=0`, `a=5`, `b=7`, `dst=3`, `we=1`, `out_valid=1`.
- Immediate extension:
  - `0x2021FFFF` (addi) → `b=0xFFFFFFFF`, func 0.
  - `0x3021FFFF` (andi) → `b=0x0000FFFF`, func 2.
  - `0x3C041234` (lui) → func 7, `b=0x00001234`, `dst=4`.
- Branch: `0x10220003`, `rs_val=rt_val=9` → func 1, `opcode=000100`, `we=0`; a connected ALU raises `zero_flag`.
- Backpressure: offer 3 back-to-back instructions with `out_ready=0` → first two accepted, `in_ready=0` on cycle 3. Release `out_ready` → issued in order 1, 2, then 3 accepted.
- Flush with state TWO and `in_valid=1` → `out_valid=0` and `in_ready=1` next cycle; none of the three entries ever issue.
- Illegal: `0x7C000000`, macro defined → `illegal=1`, `we=0`. Async `rst` pulse mid-stall → outputs return to reset values before the next edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and the issue-entry payload for the ALU decode/issue stage.
// ALU_ISSUE_ILLEGAL_EN adds an illegal-instruction flag to each entry.
package alu_pkg;

  localparam int unsigned SIZE   = 32;
  localparam int unsigned FUNC_W = 3;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned FN_W   = 6;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;

  localparam logic [FUNC_W-1:0] ALU_ADD = 3'd0;
  localparam logic [FUNC_W-1:0] ALU_SUB = 3'd1;
  localparam logic [FUNC_W-1:0] ALU_AND = 3'd2;
  localparam logic [FUNC_W-1:0] ALU_OR  = 3'd3;
  localparam logic [FUNC_W-1:0] ALU_NOT = 3'd4;
  localparam logic [FUNC_W-1:0] ALU_MOV = 3'd5;
  localparam logic [FUNC_W-1:0] ALU_SLT = 3'd6;
  localparam logic [FUNC_W-1:0] ALU_LUI = 3'd7;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;

  localparam logic [FN_W-1:0] FN_ADD  = 6'h20;
  localparam logic [FN_W-1:0] FN_ADDU = 6'h21;
  localparam logic [FN_W-1:0] FN_SUB  = 6'h22;
  localparam logic [FN_W-1:0] FN_SUBU = 6'h23;
  localparam logic [FN_W-1:0] FN_AND  = 6'h24;
  localparam logic [FN_W-1:0] FN_OR   = 6'h25;
  localparam logic [FN_W-1:0] FN_SLT  = 6'h2A;
  localparam logic [FN_W-1:0] FN_NOT  = 6'h30;
  localparam logic [FN_W-1:0] FN_MOV  = 6'h31;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [OP_W-1:0]   opcode;
    logic [SIZE-1:0]   a;
    logic [SIZE-1:0]   b;
    logic [REG_W-1:0]  dst;
    logic              we;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic              illegal;
`endif
  } issue_entry_t;

endpackage

// File: rtl/alu_func_decode.sv
// Combinational decode of one instruction plus operands into an issue entry.
// ALU_ISSUE_ILLEGAL_EN marks undecoded instructions in the entry.
module alu_func_decode
  import alu_pkg::*;
(
  input  logic [31:0]     instr,
  input  logic [SIZE-1:0] rs_val,
  input  logic [SIZE-1:0] rt_val,
  output issue_entry_t    entry_c
);

  logic [OP_W-1:0]  op;
  logic [FN_W-1:0]  fn;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic [IMM_W-1:0] imm;
  logic [SIZE-1:0]  imm_sext;
  logic [SIZE-1:0]  imm_zext;
  logic             legal;
  logic             unused_fields;

  assign op       = instr[31:26];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign fn       = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_sext = {{(SIZE-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_zext = SIZE'(imm);
  // rs index and shamt are not needed: operands arrive already read
  assign unused_fields = ^{instr[25:21], instr[10:6]};

  always_comb begin
    entry_c        = '0;
    entry_c.opcode = op;
    legal          = 1'b1;
    unique case (op)
      OP_RTYPE: begin
        entry_c.a   = rs_val;
        entry_c.b   = rt_val;
        entry_c.dst = rd;
        entry_c.we  = 1'b1;
        case (fn)
          FN_ADD, FN_ADDU: entry_c.func = ALU_ADD;
          FN_SUB, FN_SUBU: entry_c.func = ALU_SUB;
          FN_AND:          entry_c.func = ALU_AND;
          FN_OR:           entry_c.func = ALU_OR;
          FN_SLT:          entry_c.func = ALU_SLT;
          FN_NOT:          entry_c.func = ALU_NOT;
          FN_MOV:          entry_c.func = ALU_MOV;
          default:         legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
        entry_c.a   = rs_val;
        entry_c.dst = rt;
        entry_c.we  = (op != OP_SW);
        entry_c.b   = imm_sext;
        case (op)
          OP_SLTI: entry_c.func = ALU_SLT;
          OP_ANDI: begin entry_c.func = ALU_AND; entry_c.b = imm_zext; end
          OP_ORI:  begin entry_c.func = ALU_OR;  entry_c.b = imm_zext; end
          OP_LUI:  begin entry_c.func = ALU_LUI; entry_c.b = imm_zext; end
          default: entry_c.func = ALU_ADD;
        endcase
      end
      OP_BEQ, OP_BNE: begin
        entry_c.func = ALU_SUB;
        entry_c.a    = rs_val;
        entry_c.b    = rt_val;
      end
      default: legal = 1'b0;
    endcase

    // Undecoded instructions still issue, but as a harmless bubble
    if (!legal) begin
      entry_c        = '0;
      entry_c.opcode = op;
    end
    if (entry_c.dst == '0) entry_c.we = 1'b0;
`ifdef ALU_ISSUE_ILLEGAL_EN
    entry_c.illegal = !legal;
`endif
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage with a two-entry skid buffer feeding the pipeline ALU.
// ALU_ISSUE_ILLEGAL_EN exposes the registered illegal-instruction flag.
module alu_issue_stage
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [SIZE-1:0]   rs_val,
  input  logic [SIZE-1:0]   rt_val,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FUNC_W-1:0] func,
  output logic [OP_W-1:0]   opcode,
  output logic [SIZE-1:0]   a,
  output logic [SIZE-1:0]   b,
  output logic [REG_W-1:0]  dst,
`ifdef ALU_ISSUE_ILLEGAL_EN
  output logic              illegal,
`endif
  output logic              we
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t       state_q, state_d;
  issue_entry_t main_q, main_d, skid_q, skid_d, dec_c;
  logic         in_ready_q, out_valid_q;
  logic         accept_c, consume_c;

  alu_func_decode u_decode (
    .instr   (instr),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .entry_c (dec_c)
  );

  assign accept_c  = in_valid && in_ready_q && !flush;
  assign consume_c = out_valid_q && out_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Main register always holds the oldest entry; skid holds the younger one
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d = ST_ONE;
            main_d  = dec_c;
          end
        end
        ST_ONE: begin
          if (accept_c && consume_c) begin
            main_d = dec_c;
          end else if (accept_c) begin
            state_d = ST_TWO;
            skid_d  = dec_c;
          end else if (consume_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume_c) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign func      = main_q.func;
  assign opcode    = main_q.opcode;
  assign a         = main_q.a;
  assign b         = main_q.b;
  assign dst       = main_q.dst;
  assign we        = main_q.we;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign illegal   = main_q.illegal;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (either ALU_ISSUE_ILLEGAL_EN build).
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, we;
  logic [31:0] instr, rs_val, rt_val, a, b;
  logic [2:0]  func;
  logic [5:0]  opcode;
  logic [4:0]  dst;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        illegal;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .func(func), .opcode(opcode), .a(a), .b(b), .dst(dst),
`ifdef ALU_ISSUE_ILLEGAL_EN
    .illegal(illegal),
`endif
    .we(we)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [2:0]  e_func;
    logic [5:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [4:0]  e_dst;
    logic        e_we;
    logic        e_ill;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = v;
    instr    = i;
    rs_val   = rs;
    rt_val   = rt;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " func"}, 32'(func), 32'd0);
    check({tag, " opcode"}, 32'(opcode), 32'd0);
    check({tag, " a"}, a, 32'd0);
    check({tag, " b"}, b, 32'd0);
    check({tag, " dst"}, 32'(dst), 32'd0);
    check({tag, " we"}, 32'(we), 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    check({tag, " illegal"}, 32'(illegal), 32'd0);
`endif
  endtask

  initial begin
    //         instr          rs            rt           func  op     a             b             dst    we    ill
    vecs[0]  = '{32'h00221820, 32'd5,       32'd7,       3'd0, 6'h00, 32'd5,        32'd7,        5'd3,  1'b1, 1'b0};
    vecs[1]  = '{32'h2021FFFF, 32'd10,      32'd3,       3'd0, 6'h08, 32'd10,       32'hFFFFFFFF, 5'd1,  1'b1, 1'b0};
    vecs[2]  = '{32'h3021FFFF, 32'd10,      32'd3,       3'd2, 6'h0C, 32'd10,       32'h0000FFFF, 5'd1,  1'b1, 1'b0};
    vecs[3]  = '{32'h3C041234, 32'h55,      32'd3,       3'd7, 6'h0F, 32'h55,       32'h00001234, 5'd4,  1'b1, 1'b0};
    vecs[4]  = '{32'h10220003, 32'd9,       32'd9,       3'd1, 6'h04, 32'd9,        32'd9,        5'd0,  1'b0, 1'b0};
    vecs[5]  = '{32'h00222822, 32'd20,      32'd6,       3'd1, 6'h00, 32'd20,       32'd6,        5'd5,  1'b1, 1'b0};
    vecs[6]  = '{32'h0022302A, 32'd1,       32'd2,       3'd6, 6'h00, 32'd1,        32'd2,        5'd6,  1'b1, 1'b0};
    vecs[7]  = '{32'h00223830, 32'hF0,      32'h0F,      3'd4, 6'h00, 32'hF0,       32'h0F,       5'd7,  1'b1, 1'b0};
    vecs[8]  = '{32'h00224031, 32'hAB,      32'hCD,      3'd5, 6'h00, 32'hAB,       32'hCD,       5'd8,  1'b1, 1'b0};
    vecs[9]  = '{32'h00220020, 32'd3,       32'd4,       3'd0, 6'h00, 32'd3,        32'd4,        5'd0,  1'b0, 1'b0};
    vecs[10] = '{32'hAC22FFFC, 32'h100,     32'd77,      3'd0, 6'h2B, 32'h100,      32'hFFFFFFFC, 5'd2,  1'b0, 1'b0};
    vecs[11] = '{32'h8C220004, 32'h200,     32'd77,      3'd0, 6'h23, 32'h200,      32'd4,        5'd2,  1'b1, 1'b0};
    vecs[12] = '{32'h34228000, 32'h1,       32'd77,      3'd3, 6'h0D, 32'h1,        32'h00008000, 5'd2,  1'b1, 1'b0};
    vecs[13] = '{32'h28228000, 32'h2,       32'd77,      3'd6, 6'h0A, 32'h2,        32'hFFFF8000, 5'd2,  1'b1, 1'b0};
    vecs[14] = '{32'h7C000000, 32'd3,       32'd4,       3'd0, 6'h1F, 32'd0,        32'd0,        5'd0,  1'b0, 1'b1};
    vecs[15] = '{32'h0022183F, 32'd3,       32'd4,       3'd0, 6'h00, 32'd0,        32'd0,        5'd0,  1'b0, 1'b1};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    repeat (2) step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Streaming at full throughput with a free consumer
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].rs, vecs[i].rt);
      step();
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("v%0d func", i), 32'(func), 32'(vecs[i].e_func));
      check($sformatf("v%0d opcode", i), 32'(opcode), 32'(vecs[i].e_op));
      check($sformatf("v%0d a", i), a, vecs[i].e_a);
      check($sformatf("v%0d b", i), b, vecs[i].e_b);
      check($sformatf("v%0d dst", i), 32'(dst), 32'(vecs[i].e_dst));
      check($sformatf("v%0d we", i), 32'(we), 32'(vecs[i].e_we));
`ifdef ALU_ISSUE_ILLEGAL_EN
      check($sformatf("v%0d illegal", i), 32'(illegal), 32'(vecs[i].e_ill));
`endif
    end
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    step();
    check("drain out_valid", 32'(out_valid), 32'd0);

    // Backpressure: entries 1,2 buffered, 3 refused until space frees up
    out_ready = 1'b0;
    drive(1'b1, 32'h00221820, 32'd11, 32'd1);
    step();
    check("bp1 dst", 32'(dst), 32'd3);
    check("bp1 in_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 32'h00222822, 32'd22, 32'd2);
    step();
    check("bp2 in_ready", 32'(in_ready), 32'd0);
    check("bp2 hold a", a, 32'd11);
    drive(1'b1, 32'h0022302A, 32'd33, 32'd3);
    step();
    check("bp3 in_ready", 32'(in_ready), 32'd0);
    check("bp3 hold dst", 32'(dst), 32'd3);
    check("bp3 hold a", a, 32'd11);
    out_ready = 1'b1;
    step();
    check("bp issue2 dst", 32'(dst), 32'd5);
    check("bp issue2 a", a, 32'd22);
    check("bp issue2 in_ready", 32'(in_ready), 32'd1);
    step();
    check("bp issue3 dst", 32'(dst), 32'd6);
    check("bp issue3 a", a, 32'd33);
    check("bp issue3 valid", 32'(out_valid), 32'd1);
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    step();
    check("bp empty", 32'(out_valid), 32'd0);

    // Flush in TWO with a third instruction offered: nothing issues
    out_ready = 1'b0;
    drive(1'b1, 32'h00221820, 32'd1, 32'd1);
    step();
    drive(1'b1, 32'h00222822, 32'd2, 32'd2);
    step();
    check("fl pre in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 32'h0022302A, 32'd3, 32'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    check("fl out_valid", 32'(out_valid), 32'd0);
    check("fl in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fl idle%0d out_valid", i), 32'(out_valid), 32'd0);
    end

    // Asynchronous reset while stalled with both entries full
    out_ready = 1'b0;
    drive(1'b1, 32'h00221820, 32'd4, 32'd4);
    step();
    drive(1'b1, 32'h00222822, 32'd5, 32'd5);
    step();
    drive(1'b0, 32'd0, 32'd0, 32'd0);
    check("ar pre out_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_reset_values("async rst");
    rst = 1'b0;
    step();
    check("ar post out_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
